// File: rtl/lce_pkg.sv
// Shared state encoding and saturation helpers for the linear classifier engine.
package lce_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      ARGMAX
   } state_t;

   // Clamp x to the range of a bits-wide two's complement number.
   function automatic logic signed [63:0] sat_signed(input logic signed [63:0] x,
                                                      input int unsigned      bits);
      logic signed [63:0] max_v;
      logic signed [63:0] min_v;
      max_v = (64'sd1 <<< (bits - 1)) - 64'sd1;
      min_v = -(64'sd1 <<< (bits - 1));
      if (x > max_v) return max_v;
      if (x < min_v) return min_v;
      return x;
   endfunction

   // a - b clamped to [0, 2^bits - 1].
   function automatic logic [63:0] sat_unsigned_diff(input logic signed [63:0] a,
                                                      input logic signed [63:0] b,
                                                      input int unsigned      bits);
      logic signed [63:0] d;
      logic signed [63:0] max_v;
      d     = a - b;
      max_v = (64'sd1 <<< bits) - 64'sd1;
      if (d < 0) return '0;
      if (d > max_v) return max_v;
      return d;
   endfunction

endpackage

// File: rtl/lce_if.sv
// Feature stream bundle: valid/ready handshake carrying LANES cells per beat.
interface lce_if #(
   parameter int LANES      = 2,
   parameter int VALUE_BITS = 8
);
   logic                        feat_valid;
   logic                        feat_ready;
   logic [LANES*VALUE_BITS-1:0] feat_data;

   modport master (output feat_valid, output feat_data, input feat_ready);
   modport slave  (input feat_valid, input feat_data, output feat_ready);
endinterface

// File: rtl/lce_top2_argmax.sv
// Combinational top-2 search over the class scores; ties go to the lowest index.
module lce_top2_argmax
   import lce_pkg::*;
#(
   parameter int NUM_CLASSES = 4,
   parameter int ACC_BITS    = 24,
   parameter int CW          = 2
) (
   input  logic [NUM_CLASSES*ACC_BITS-1:0] scores_flat,
   output logic [CW-1:0]                   best,
   output logic [CW-1:0]                   second,
   output logic [ACC_BITS-1:0]             margin
);

   logic signed [ACC_BITS-1:0] cur_s;
   logic signed [ACC_BITS-1:0] best_s;
   logic signed [ACC_BITS-1:0] second_s;
   logic                       have_second;

   // NOTE: every variable gets a default before any branch so no path can infer a latch.
   always_comb begin
      best        = '0;
      second      = '0;
      margin      = '0;
      cur_s       = '0;
      have_second = 1'b0;
      best_s      = scores_flat[ACC_BITS-1:0];
      second_s    = '0;

      for (int c = 1; c < NUM_CLASSES; c++) begin
         cur_s = scores_flat[c*ACC_BITS +: ACC_BITS];
         if (cur_s > best_s) begin
            best_s = cur_s;
            best   = CW'(c);
         end
      end

      for (int c = 0; c < NUM_CLASSES; c++) begin
         cur_s = scores_flat[c*ACC_BITS +: ACC_BITS];
         if ((CW'(c) != best) && (!have_second || (cur_s > second_s))) begin
            second_s    = cur_s;
            second      = CW'(c);
            have_second = 1'b1;
         end
      end

      if (have_second)
         margin = ACC_BITS'(sat_unsigned_diff(64'(best_s), 64'(second_s), ACC_BITS));
   end

endmodule

// File: rtl/linear_classifier_engine.sv
// Streams feature beats against per-class weight ROMs, accumulates saturated
// scores on top of per-class biases and reports the top-2 classes and margin.
module linear_classifier_engine
   import lce_pkg::*;
#(
   parameter int  NUM_CLASSES = 4,
   parameter int  NUM_CELLS   = 1024,
   parameter int  LANES       = 2,
   parameter int  VALUE_BITS  = 8,
   parameter int  WEIGHT_BITS = 8,
   parameter int  ACC_BITS    = 24,
   localparam int BEATS       = NUM_CELLS / LANES,
   localparam int AW          = (BEATS > 1) ? $clog2(BEATS) : 1,
   localparam int CW          = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  start,
   input  logic                                  abort,
   input  logic [NUM_CLASSES*ACC_BITS-1:0]       bias_flat,
   lce_if.slave                                  feat,
   output logic [AW-1:0]                         w_addr,
   input  logic [NUM_CLASSES*LANES*WEIGHT_BITS-1:0] w_data,
   output logic                                  busy,
   output logic                                  result_valid,
   output logic [CW-1:0]                         best_class,
   output logic [CW-1:0]                         second_class,
   output logic [ACC_BITS-1:0]                   margin,
   output logic [NUM_CLASSES*ACC_BITS-1:0]       scores_flat
);

   localparam int BCW   = $clog2(BEATS + 1);
   localparam int PW    = VALUE_BITS + WEIGHT_BITS + 1;
   localparam int SUM_W = ACC_BITS + $clog2(LANES) + 1;

   state_t                      state;
   state_t                      state_nxt;
   logic [BCW-1:0]              beat_cnt;
   logic [LANES*VALUE_BITS-1:0] feat_q;
   logic                        pipe_valid;
   logic                        accept;
   logic                        load;
   logic                        latch;

   logic signed [ACC_BITS-1:0]     acc     [NUM_CLASSES];
   logic signed [ACC_BITS-1:0]     acc_nxt [NUM_CLASSES];
   logic [NUM_CLASSES*ACC_BITS-1:0] acc_flat;
   logic signed [PW-1:0]           prod;
   logic signed [SUM_W-1:0]        lane_sum;

   logic [CW-1:0]       top_best;
   logic [CW-1:0]       top_second;
   logic [ACC_BITS-1:0] top_margin;

   assign feat.feat_ready = (state == RUN) && (beat_cnt < BCW'(BEATS));
   assign accept          = feat.feat_valid && feat.feat_ready;
   assign busy            = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // abort outranks both the start in IDLE and the result latch in ARGMAX.
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      latch     = 1'b0;
      case (state)
         IDLE: begin
            if (start && !abort) begin
               state_nxt = RUN;
               load      = 1'b1;
            end
         end
         RUN: begin
            if (abort)                                          state_nxt = IDLE;
            else if (accept && (beat_cnt == BCW'(BEATS - 1)))   state_nxt = DRAIN;
         end
         DRAIN:   state_nxt = abort ? IDLE : ARGMAX;
         ARGMAX: begin
            state_nxt = IDLE;
            latch     = !abort;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Lane products are formed at full width and summed before the single clamp.
   always_comb begin
      acc_nxt  = '{default: '0};
      prod     = '0;
      lane_sum = '0;
      for (int c = 0; c < NUM_CLASSES; c++) begin
         lane_sum = '0;
         for (int i = 0; i < LANES; i++) begin
            prod = PW'($signed({1'b0, feat_q[i*VALUE_BITS +: VALUE_BITS]}))
                 * PW'($signed(w_data[(c*LANES+i)*WEIGHT_BITS +: WEIGHT_BITS]));
            lane_sum = lane_sum + SUM_W'(prod);
         end
         acc_nxt[c] = ACC_BITS'(sat_signed(64'(lane_sum) + 64'(acc[c]), ACC_BITS));
      end
   end

   always_comb begin
      acc_flat = '0;
      for (int c = 0; c < NUM_CLASSES; c++)
         acc_flat[c*ACC_BITS +: ACC_BITS] = acc[c];
   end

   lce_top2_argmax #(
      .NUM_CLASSES (NUM_CLASSES),
      .ACC_BITS    (ACC_BITS),
      .CW          (CW)
   ) u_argmax (
      .scores_flat (acc_flat),
      .best        (top_best),
      .second      (top_second),
      .margin      (top_margin)
   );

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         beat_cnt     <= '0;
         w_addr       <= '0;
         feat_q       <= '0;
         pipe_valid   <= 1'b0;
         // NOTE: acc is a small register bank, not a RAM, so it is cleared with the rest.
         for (int c = 0; c < NUM_CLASSES; c++) acc[c] <= '0;
         result_valid <= 1'b0;
         scores_flat  <= '0;
         best_class   <= '0;
         second_class <= '0;
         margin       <= '0;
      end else begin
         pipe_valid   <= accept && !abort;
         result_valid <= latch;
         if (accept) feat_q <= feat.feat_data;

         if (load) begin
            beat_cnt <= '0;
            w_addr   <= '0;
            for (int c = 0; c < NUM_CLASSES; c++)
               acc[c] <= bias_flat[c*ACC_BITS +: ACC_BITS];
         end else begin
            if (accept) begin
               beat_cnt <= beat_cnt + BCW'(1);
               if (w_addr != AW'(BEATS - 1)) w_addr <= w_addr + AW'(1);
            end
            if (pipe_valid)
               for (int c = 0; c < NUM_CLASSES; c++) acc[c] <= acc_nxt[c];
         end

         if (latch) begin
            scores_flat  <= acc_flat;
            best_class   <= top_best;
            second_class <= top_second;
            margin       <= top_margin;
         end
      end
   end

endmodule

// File: tb/tb_linear_classifier_engine.sv
// Directed bench for linear_classifier_engine: an array-based score model plus
// a per-cycle output compare, with literal expectations pinning key runs.
module tb_linear_classifier_engine;

   localparam int NUM_CLASSES = 4;
   localparam int NUM_CELLS   = 8;
   localparam int LANES       = 2;
   localparam int VALUE_BITS  = 8;
   localparam int WEIGHT_BITS = 8;
   localparam int ACC_BITS    = 16;
   localparam int BEATS       = NUM_CELLS / LANES;
   localparam int AW          = 2;
   localparam int CW          = 2;
   localparam longint SMAX    = (longint'(1) << (ACC_BITS - 1)) - 1;
   localparam longint SMIN    = -(longint'(1) << (ACC_BITS - 1));
   localparam longint UMAX    = (longint'(1) << ACC_BITS) - 1;

   logic clk;
   logic rst;
   logic start;
   logic abort;
   logic [NUM_CLASSES*ACC_BITS-1:0]          bias_flat;
   logic [AW-1:0]                            w_addr;
   logic [NUM_CLASSES*LANES*WEIGHT_BITS-1:0] w_data;
   logic                                     busy;
   logic                                     result_valid;
   logic [CW-1:0]                            best_class;
   logic [CW-1:0]                            second_class;
   logic [ACC_BITS-1:0]                      margin;
   logic [NUM_CLASSES*ACC_BITS-1:0]          scores_flat;

   lce_if #(.LANES(LANES), .VALUE_BITS(VALUE_BITS)) feat_bus ();

   linear_classifier_engine #(
      .NUM_CLASSES (NUM_CLASSES),
      .NUM_CELLS   (NUM_CELLS),
      .LANES       (LANES),
      .VALUE_BITS  (VALUE_BITS),
      .WEIGHT_BITS (WEIGHT_BITS),
      .ACC_BITS    (ACC_BITS)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .abort        (abort),
      .bias_flat    (bias_flat),
      .feat         (feat_bus),
      .w_addr       (w_addr),
      .w_data       (w_data),
      .busy         (busy),
      .result_valid (result_valid),
      .best_class   (best_class),
      .second_class (second_class),
      .margin       (margin),
      .scores_flat  (scores_flat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int feat_mem [BEATS][LANES];
   int w_mem    [BEATS][NUM_CLASSES][LANES];
   int bias     [NUM_CLASSES];

   longint pend_score [NUM_CLASSES];
   longint pend_best, pend_second, pend_margin;
   longint held_score [NUM_CLASSES];
   longint held_best, held_second, held_margin;

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;
   int start_cyc = 0;
   int exp_latency = -1;
   bit run_expected = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [NUM_CLASSES*LANES*WEIGHT_BITS-1:0] pack_w(input int a);
      logic [NUM_CLASSES*LANES*WEIGHT_BITS-1:0] v;
      v = '0;
      for (int c = 0; c < NUM_CLASSES; c++)
         for (int i = 0; i < LANES; i++)
            v[(c*LANES+i)*WEIGHT_BITS +: WEIGHT_BITS] = WEIGHT_BITS'(w_mem[a][c][i]);
      return v;
   endfunction

   // Synchronous weight ROM, one cycle of read latency.
   always @(posedge clk) w_data <= pack_w(int'(w_addr));

   function automatic logic [LANES*VALUE_BITS-1:0] pack_feat(input int b);
      logic [LANES*VALUE_BITS-1:0] v;
      v = '0;
      for (int i = 0; i < LANES; i++)
         v[i*VALUE_BITS +: VALUE_BITS] = VALUE_BITS'(feat_mem[b][i]);
      return v;
   endfunction

   function automatic logic [NUM_CLASSES*ACC_BITS-1:0] pack_bias();
      logic [NUM_CLASSES*ACC_BITS-1:0] v;
      v = '0;
      for (int c = 0; c < NUM_CLASSES; c++)
         v[c*ACC_BITS +: ACC_BITS] = ACC_BITS'(bias[c]);
      return v;
   endfunction

   function automatic longint dut_score(input int c);
      return longint'($signed(scores_flat[c*ACC_BITS +: ACC_BITS]));
   endfunction

   task automatic check(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: per-beat dot product, clamp after each beat, then a plain top-2 scan.
   function automatic void compute_model();
      longint acc [NUM_CLASSES];
      longint s;
      int b1, b2;
      for (int c = 0; c < NUM_CLASSES; c++) acc[c] = bias[c];
      for (int b = 0; b < BEATS; b++)
         for (int c = 0; c < NUM_CLASSES; c++) begin
            s = 0;
            for (int i = 0; i < LANES; i++) s += longint'(feat_mem[b][i]) * w_mem[b][c][i];
            acc[c] += s;
            if (acc[c] > SMAX) acc[c] = SMAX;
            if (acc[c] < SMIN) acc[c] = SMIN;
         end
      b1 = 0;
      for (int c = 1; c < NUM_CLASSES; c++) if (acc[c] > acc[b1]) b1 = c;
      b2 = (b1 == 0) ? 1 : 0;
      for (int c = 0; c < NUM_CLASSES; c++) if (c != b1 && acc[c] > acc[b2]) b2 = c;
      for (int c = 0; c < NUM_CLASSES; c++) pend_score[c] = acc[c];
      pend_best   = b1;
      pend_second = b2;
      pend_margin = acc[b1] - acc[b2];
      if (pend_margin > UMAX) pend_margin = UMAX;
   endfunction

   // Per-cycle compare: registered outputs must always equal the last completed result.
   always @(negedge clk) begin
      if (rst) begin
         for (int c = 0; c < NUM_CLASSES; c++) held_score[c] = 0;
         held_best    = 0;
         held_second  = 0;
         held_margin  = 0;
         run_expected = 1'b0;
      end else begin
         if (result_valid) begin
            check("result_valid_expected", longint'(result_valid), longint'(run_expected));
            if (run_expected) begin
               if (exp_latency >= 0) check("latency", cyc - start_cyc, exp_latency);
               for (int c = 0; c < NUM_CLASSES; c++) held_score[c] = pend_score[c];
               held_best    = pend_best;
               held_second  = pend_second;
               held_margin  = pend_margin;
               run_expected = 1'b0;
            end
         end
         for (int c = 0; c < NUM_CLASSES; c++)
            check($sformatf("score%0d", c), dut_score(c), held_score[c]);
         check("best_class", longint'(best_class), held_best);
         check("second_class", longint'(second_class), held_second);
         check("margin", longint'(margin), held_margin);
      end
   end

   // Runs one inference; events are keyed to the drive slot (slot 0 = first cycle in RUN).
   task automatic drive_run(input bit stall, input int abort_slot, input int start_slot,
                            input int rst_slot, input int exp_lat);
      int  k    = 0;
      int  slot = 0;
      bit  stop = 1'b0;
      bit  v;
      compute_model();
      @(negedge clk);
      bias_flat    = pack_bias();
      start        = 1'b1;
      start_cyc    = cyc + 1;
      exp_latency  = exp_lat;
      run_expected = (abort_slot < 0) && (rst_slot < 0);
      @(negedge clk);
      start = 1'b0;
      while (k < BEATS && slot < 100 && !stop) begin
         check("w_addr_tracks_accepts", longint'(w_addr), k);
         start = (slot == start_slot);
         if (slot == rst_slot) begin
            rst                 = 1'b1;
            feat_bus.feat_valid = 1'b0;
            stop                = 1'b1;
         end else if (slot == abort_slot) begin
            abort               = 1'b1;
            feat_bus.feat_valid = 1'b0;
            stop                = 1'b1;
         end else begin
            v = !stall || (slot % 3 == 0);
            feat_bus.feat_valid = v;
            feat_bus.feat_data  = pack_feat(k);
            if (v && feat_bus.feat_ready) k++;
         end
         slot++;
         @(negedge clk);
      end
      start               = 1'b0;
      abort               = 1'b0;
      feat_bus.feat_valid = 1'b0;
      if (!stop) check("beats_accepted", k, BEATS);

      if (rst_slot >= 0) begin
         @(negedge clk);
         rst = 1'b0;
         check("rst_busy", longint'(busy), 0);
         check("rst_feat_ready", longint'(feat_bus.feat_ready), 0);
         check("rst_result_valid", longint'(result_valid), 0);
         check("rst_w_addr", longint'(w_addr), 0);
         check("rst_best", longint'(best_class), 0);
         check("rst_margin", longint'(margin), 0);
         check("rst_score3", dut_score(3), 0);
         @(negedge clk);
      end else if (abort_slot >= 0) begin
         check("abort_busy", longint'(busy), 0);
         check("abort_feat_ready", longint'(feat_bus.feat_ready), 0);
         repeat (8) @(negedge clk);
      end else begin
         check("w_addr_saturated", longint'(w_addr), BEATS - 1);
         for (int n = 0; n < 30 && run_expected; n++) @(negedge clk);
         check("result_seen", longint'(run_expected), 0);
         @(negedge clk);
      end
   endtask

   task automatic fill_random();
      for (int b = 0; b < BEATS; b++)
         for (int i = 0; i < LANES; i++) begin
            feat_mem[b][i] = int'($urandom_range(63, 0));
            for (int c = 0; c < NUM_CLASSES; c++)
               w_mem[b][c][i] = int'($urandom_range(63, 0)) - 32;
         end
      for (int c = 0; c < NUM_CLASSES; c++) bias[c] = int'($urandom_range(200, 0)) - 100;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      rst                 = 1'b1;
      start               = 1'b0;
      abort               = 1'b0;
      bias_flat           = '0;
      feat_bus.feat_valid = 1'b0;
      feat_bus.feat_data  = '0;
      for (int b = 0; b < BEATS; b++)
         for (int i = 0; i < LANES; i++) begin
            feat_mem[b][i] = 0;
            for (int c = 0; c < NUM_CLASSES; c++) w_mem[b][c][i] = 0;
         end
      for (int c = 0; c < NUM_CLASSES; c++) bias[c] = 0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      check("reset_busy", longint'(busy), 0);
      check("reset_feat_ready", longint'(feat_bus.feat_ready), 0);
      check("reset_result_valid", longint'(result_valid), 0);
      check("reset_w_addr", longint'(w_addr), 0);
      check("reset_second", longint'(second_class), 0);
      check("reset_score0", dut_score(0), 0);

      // Base dot product: features 1, class k weight k+1, zero bias.
      for (int b = 0; b < BEATS; b++)
         for (int i = 0; i < LANES; i++) begin
            feat_mem[b][i] = 1;
            for (int c = 0; c < NUM_CLASSES; c++) w_mem[b][c][i] = c + 1;
         end
      drive_run(1'b0, -1, -1, -1, BEATS + 2);
      check("base_score0", dut_score(0), 8);
      check("base_score1", dut_score(1), 16);
      check("base_score2", dut_score(2), 24);
      check("base_score3", dut_score(3), 32);
      check("base_best", longint'(best_class), 3);
      check("base_second", longint'(second_class), 2);
      check("base_margin", longint'(margin), 8);

      // Bias levels every class to 32: tie resolves to lowest indices.
      bias[0] = 24; bias[1] = 16; bias[2] = 8; bias[3] = 0;
      drive_run(1'b0, -1, -1, -1, BEATS + 2);
      check("tie_score0", dut_score(0), 32);
      check("tie_score3", dut_score(3), 32);
      check("tie_best", longint'(best_class), 0);
      check("tie_second", longint'(second_class), 1);
      check("tie_margin", longint'(margin), 0);

      // Saturation at both rails and an unsigned margin of 2^16-1.
      for (int c = 0; c < NUM_CLASSES; c++) bias[c] = 0;
      for (int b = 0; b < BEATS; b++)
         for (int i = 0; i < LANES; i++) begin
            feat_mem[b][i] = 255;
            for (int c = 0; c < NUM_CLASSES; c++) w_mem[b][c][i] = (c == 0) ? 127 : -128;
         end
      drive_run(1'b0, -1, -1, -1, BEATS + 2);
      check("sat_score0", dut_score(0), 32767);
      check("sat_score1", dut_score(1), -32768);
      check("sat_best", longint'(best_class), 0);
      check("sat_second", longint'(second_class), 1);
      check("sat_margin", longint'(margin), 65535);

      // Stalled stream with valid pattern 1,0,0,1,...
      fill_random();
      drive_run(1'b1, -1, -1, -1, -1);

      // Abort on beat 2, then a fresh run that must not see the aborted data.
      fill_random();
      drive_run(1'b0, 2, -1, -1, -1);
      fill_random();
      drive_run(1'b0, -1, -1, -1, BEATS + 2);

      // A start pulse while running changes nothing.
      fill_random();
      drive_run(1'b0, -1, 1, -1, BEATS + 2);

      // Reset in the middle of a run.
      fill_random();
      drive_run(1'b0, -1, -1, 1, -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/linear_classifier_engine.md
Name: linear_classifier_engine

Overview:
Multi-lane linear classifier that streams a feature vector against per-class signed weight ROMs. It accumulates per-class scores with saturation, adds per-class biases, and reports the best class, the runner-up and the top-1/top-2 confidence margin. It is the next generation of the gradient-map classifier MAC stage, generalised to any class count, LANES cells per beat, a valid/ready feature stream with stalls, and abort. It sits between the feature-map readout and the gesture decision logic.

Parameters:
NUM_CLASSES, 4, number of classes (>=1)
NUM_CELLS, 1024, feature cells per vector; must be a multiple of LANES
LANES, 2, cells consumed per accepted beat
VALUE_BITS, 8, feature width; features are unsigned
WEIGHT_BITS, 8, signed weight width
ACC_BITS, 24, signed accumulator, score and bias width
Derived: BEATS = NUM_CELLS/LANES; AW = max(1, $clog2(BEATS)); CW = max(1, $clog2(NUM_CLASSES))

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
start  in  1  begin inference; honoured only in IDLE
abort  in  1  cancel the inference in progress
bias_flat  in  NUM_CLASSES*ACC_BITS  signed per-class bias; sampled on the start cycle
feat_valid  in  1  feature beat valid
feat_ready  out  1  engine accepts a beat
feat_data  in  LANES*VALUE_BITS  lane i is bits [(i+1)*VALUE_BITS-1 : i*VALUE_BITS] = cell beat*LANES+i
w_addr  out  AW  weight ROM beat address (registered)
w_data  in  NUM_CLASSES*LANES*WEIGHT_BITS  synchronous ROM output, 1-cycle latency; field (class c, lane i) at index c*LANES+i
busy  out  1  high whenever the state is not IDLE
result_valid  out  1  one-cycle pulse
best_class  out  CW  top-scoring class
second_class  out  CW  runner-up class
margin  out  ACC_BITS  top1 minus top2 score; unsigned and saturated
scores_flat  out  NUM_CLASSES*ACC_BITS  registered final scores

Behaviour:
- Reset: state IDLE. All outputs, accumulators and pipeline registers are 0, and feat_ready is 0.
- States: IDLE, RUN, DRAIN, ARGMAX.
- IDLE -> RUN on start. On that edge: acc[c] <= bias[c], beat_cnt <= 0, w_addr <= 0.
- A start pulse while not in IDLE is ignored.
- feat_ready = (state==RUN) && (beat_cnt < BEATS). It is combinational from registered state only.
- On an accepted beat (feat_valid && feat_ready):
  - feat_data is registered.
  - The pipe_valid flag is set.
  - beat_cnt and w_addr increment. w_addr saturates at BEATS-1.
  - w_data seen in the next cycle therefore belongs to the accepted beat.
- On a non-accepted cycle, pipe_valid is cleared. Stalls insert bubbles only, with no loss or duplication.
- MAC: in any cycle where pipe_valid is set, acc[c] <= sat(acc[c] + sum over i of ({1'b0,feat_i} * w[c][i])).
  - Each product is signed, VALUE_BITS+WEIGHT_BITS+1 bits.
  - The lane sum is computed at full width, ACC_BITS + $clog2(LANES) + 1 bits.
  - sat clamps to [-2^(ACC_BITS-1), 2^(ACC_BITS-1)-1].
- RUN -> DRAIN on the edge accepting beat BEATS-1.
- DRAIN performs the final MAC, then moves to ARGMAX.
- ARGMAX, on its edge:
  - Registers scores_flat, best_class, second_class and margin.
  - Pulses result_valid for one cycle.
  - Returns to IDLE.
- Argmax rules:
  - Strict greater-than comparison; ties resolve to the lowest index.
  - second_class is the best among the remaining classes, same tie rule.
  - margin = sat_unsigned(top1 - top2).
  - NUM_CLASSES==1: second_class = 0 and margin = 0.
- Outputs hold their values until the next ARGMAX edge.
- Latency with no stalls: result_valid is high BEATS+2 cycles after the start edge.
- abort in RUN, DRAIN or ARGMAX: next state IDLE, no result_valid, previous results retained, feat_ready drops the following cycle. abort has priority over the ARGMAX latch.
- abort in IDLE has no effect. abort and start together in IDLE: abort wins and start is ignored.
- rst mid-operation: immediate return to reset values.

Decomposition:
- Package lce_pkg holds:
  - the state_t enum;
  - a sat_signed function, generic via parameterised class or width arguments;
  - a sat_unsigned_diff function.
- Sub-module lce_top2_argmax: combinational top-2 search over NUM_CLASSES scores, outputting best, second and margin. It is instantiated once and its outputs are registered in ARGMAX.

Test Plan:
- Base dot product. NUM_CELLS=8, LANES=2, all features 1, weight for class k = k+1, bias 0, feat_valid always 1.
  -> scores 8, 16, 24, 32; best=3; second=2; margin=8; result_valid at cycle start+6.
- Bias and tie. Same stimulus, bias = {24, 16, 8, 0} (class 0 first).
  -> all scores 32; best=0; second=1; margin=0.
- Saturation. ACC_BITS=16, features 255, weights +127 for class 0 and -128 for class 1, NUM_CELLS=8.
  -> class 0 score 32767 and class 1 score -32768 (both clamped); margin=65535 clamped to 32767? No: margin saturates unsigned to 65535.
- Stall. Toggle feat_valid 1,0,0,1,… with random data.
  -> scores identical to the no-stall reference model; no beat accepted twice; w_addr advances only on accepts.
- Abort. abort asserted on beat 2, then a new start.
  -> no result_valid for the aborted run; prior outputs held; second run's scores exclude all aborted data.
- Start during busy and reset mid-run. start pulse in RUN, then rst in RUN.
  -> the start pulse changes nothing; after rst all outputs are 0, feat_ready is 0 and busy is 0.
